mc_controller: RTL and testbench

Multi-cycle control unit for the MIPS core. It replaces single-cycle decode with a registered state machine that sequences Fetch/Decode/Execute/Memory/Writeback over a shared instruction/data memory port. The memory port uses a req/ready handshake with variable wait states and a bus-error timeout. It emits per-cycle datapath strobes and halts on syscall, illegal opcode or memory timeout; a retired-instruction counter is exported.

---
 rtl/mc_controller_if.sv | 31 +++
 rtl/mc_controller.sv | 306 ++++++++++++++++++++++++++++++
 tb/tb_mc_controller.sv | 377 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mc_controller_if.sv
// -----------------------------------------------------------------------------
// mc_controller_if
// Shared instruction/data memory port of the multi-cycle MIPS control unit.
// The controller (master) raises mem_req and holds it until the memory
// (slave) answers with mem_ready in the cycle the request completes.
//
//   mem_req   master -> slave  request active, held until mem_ready
//   mem_we    master -> slave  write strobe, meaningful only with mem_req
//   i_or_d    master -> slave  0 = address from PC, 1 = from ALU result reg
//   mem_ready slave -> master  current request completes this cycle
// -----------------------------------------------------------------------------
interface mc_controller_if;
    logic mem_req;
    logic mem_we;
    logic i_or_d;
    logic mem_ready;

    modport master (
        output mem_req,
        output mem_we,
        output i_or_d,
        input  mem_ready
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  i_or_d,
        output mem_ready
    );
endinterface

// File: rtl/mc_controller.sv
// -----------------------------------------------------------------------------
// mc_controller
// Multi-cycle control unit for the MIPS core. A registered state machine
// sequences FETCH / DECODE / EXEC / MEM / WB over a single shared memory
// port, produces the per-cycle datapath strobes, halts on syscall, an
// unsupported instruction or a memory timeout, and counts retired
// instructions.
//
// Ports
//   clk, rst        rising-edge clock, synchronous active-high reset
//   mem             memory handshake (mem_req/mem_we/i_or_d out, mem_ready in)
//   op, funct       IR[31:26] and IR[5:0], valid from DECODE onward
//   alu_zero        ALU zero flag, used by beq/bne in EXEC
//   ir_we, pc_we    IR and PC write enables
//   pc_src          0 PC+4, 1 branch target, 2 jump target, 3 rs (jr)
//   aluop           ALU operation (low 4 bits meaningful)
//   alu_src         operand B = immediate
//   shift/shift_var operand A = shamt / rs[4:0]
//   usign           unsigned arithmetic (addu, addiu)
//   load_imm        lui writeback path
//   reg_we, reg_dst register write, destination rd (1) or rt (0)
//   jal             write PC+4 to $31
//   mem_to_reg      writeback from memory data register
//   halted          FSM is in HALT
//   halt_cause      0 none, 1 syscall, 2 illegal, 3 bus timeout
//   retired         completed-instruction count, wraps
// -----------------------------------------------------------------------------
module mc_controller #(
    parameter int ALUOP_W     = 4,
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic               clk,
    input  logic               rst,
    mc_controller_if.master    mem,
    input  logic [5:0]         op,
    input  logic [5:0]         funct,
    input  logic               alu_zero,
    output logic               ir_we,
    output logic               pc_we,
    output logic [1:0]         pc_src,
    output logic [ALUOP_W-1:0] aluop,
    output logic               alu_src,
    output logic               shift,
    output logic               shift_var,
    output logic               usign,
    output logic               load_imm,
    output logic               reg_we,
    output logic               reg_dst,
    output logic               jal,
    output logic               mem_to_reg,
    output logic               halted,
    output logic [1:0]         halt_cause,
    output logic [CNT_W-1:0]   retired
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_e;

    typedef enum logic [3:0] {
        K_ALU, K_LW, K_SW, K_BEQ, K_BNE, K_J, K_JAL, K_JR, K_SYSCALL, K_ILLEGAL
    } kind_e;

    typedef enum logic [1:0] {
        CAUSE_NONE    = 2'd0,
        CAUSE_SYSCALL = 2'd1,
        CAUSE_ILLEGAL = 2'd2,
        CAUSE_TIMEOUT = 2'd3
    } cause_e;

    localparam logic [5:0] OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_JAL  = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04, OP_BNE  = 6'h05, OP_ADDI = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09, OP_SLTI = 6'h0a, OP_ANDI = 6'h0c;
    localparam logic [5:0] OP_ORI   = 6'h0d, OP_LUI  = 6'h0f, OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [5:0] F_SLL  = 6'h00, F_SRL  = 6'h02, F_SRA     = 6'h03;
    localparam logic [5:0] F_SLLV = 6'h04, F_SRAV = 6'h07, F_JR      = 6'h08;
    localparam logic [5:0] F_SYSC = 6'h0c, F_ADD  = 6'h20, F_ADDU    = 6'h21;
    localparam logic [5:0] F_SUB  = 6'h22, F_AND  = 6'h24, F_OR      = 6'h25;
    localparam logic [5:0] F_NOR  = 6'h27, F_SLT  = 6'h2a, F_SLTU    = 6'h2b;

    // Timeout counter only needs to reach MEM_TIMEOUT-1; a waiting cycle
    // at that count is the MEM_TIMEOUT-th one and triggers the bus error.
    localparam int TMO_W     = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam int TMO_LIMIT = (MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0;

    state_e             state_q, state_d;
    cause_e             cause_q, cause_d;
    logic [CNT_W-1:0]   retired_q, retired_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;

    kind_e              dec_kind;
    logic [3:0]         dec_alu;
    logic               dec_imm, dec_shift, dec_shvar, dec_usign;
    logic [3:0]         alu4;
    logic               mem_wait;

    // -------------------------------------------------------------------------
    // Instruction decode: classifies op/funct and yields the EXEC-stage ALU
    // controls. Anything not listed falls through to K_ILLEGAL.
    // -------------------------------------------------------------------------
    // NOTE: every variable gets a default before the case statements, so no
    // path through this combinational block can leave one unassigned (latch).
    always_comb begin
        dec_kind  = K_ILLEGAL;
        dec_alu   = 4'b0101;
        dec_imm   = 1'b0;
        dec_shift = 1'b0;
        dec_shvar = 1'b0;
        dec_usign = 1'b0;
        if (op == OP_RTYPE) begin
            case (funct)
                F_SLL:  begin dec_kind = K_ALU; dec_alu = 4'b0000; dec_shift = 1'b1; end
                F_SRL:  begin dec_kind = K_ALU; dec_alu = 4'b0010; dec_shift = 1'b1; end
                F_SRA:  begin dec_kind = K_ALU; dec_alu = 4'b0001; dec_shift = 1'b1; end
                F_SLLV: begin dec_kind = K_ALU; dec_alu = 4'b0000; dec_shvar = 1'b1; end
                F_SRAV: begin dec_kind = K_ALU; dec_alu = 4'b0001; dec_shvar = 1'b1; end
                F_JR:   dec_kind = K_JR;
                F_SYSC: dec_kind = K_SYSCALL;
                F_ADD:  dec_kind = K_ALU;
                F_ADDU: begin dec_kind = K_ALU; dec_usign = 1'b1; end
                F_SUB:  begin dec_kind = K_ALU; dec_alu = 4'b0110; end
                F_AND:  begin dec_kind = K_ALU; dec_alu = 4'b0111; end
                F_OR:   begin dec_kind = K_ALU; dec_alu = 4'b1000; end
                F_NOR:  begin dec_kind = K_ALU; dec_alu = 4'b1010; end
                F_SLT:  begin dec_kind = K_ALU; dec_alu = 4'b1011; end
                F_SLTU: begin dec_kind = K_ALU; dec_alu = 4'b1100; end
                default: ;
            endcase
        end else begin
            case (op)
                OP_ADDI:  begin dec_kind = K_ALU; dec_imm = 1'b1; end
                OP_ADDIU: begin dec_kind = K_ALU; dec_imm = 1'b1; dec_usign = 1'b1; end
                OP_ANDI:  begin dec_kind = K_ALU; dec_imm = 1'b1; dec_alu = 4'b0111; end
                OP_ORI:   begin dec_kind = K_ALU; dec_imm = 1'b1; dec_alu = 4'b1000; end
                OP_SLTI:  begin dec_kind = K_ALU; dec_imm = 1'b1; dec_alu = 4'b1011; end
                OP_LUI:   begin dec_kind = K_ALU; dec_imm = 1'b1; end
                OP_LW:    begin dec_kind = K_LW;  dec_imm = 1'b1; end
                OP_SW:    begin dec_kind = K_SW;  dec_imm = 1'b1; end
                OP_BEQ:   begin dec_kind = K_BEQ; dec_alu = 4'b0110; end
                OP_BNE:   begin dec_kind = K_BNE; dec_alu = 4'b0110; end
                OP_J:     dec_kind = K_J;
                OP_JAL:   dec_kind = K_JAL;
                default: ;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and strobe generation.
    // -------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        cause_d     = cause_q;
        retired_d   = retired_q;
        tmo_d       = tmo_q;
        mem_wait    = 1'b0;
        mem.mem_req = 1'b0;
        mem.mem_we  = 1'b0;
        mem.i_or_d  = 1'b0;
        ir_we       = 1'b0;
        pc_we       = 1'b0;
        pc_src      = 2'd0;
        alu4        = 4'b0000;
        alu_src     = 1'b0;
        shift       = 1'b0;
        shift_var   = 1'b0;
        usign       = 1'b0;
        load_imm    = 1'b0;
        reg_we      = 1'b0;
        reg_dst     = 1'b0;
        jal         = 1'b0;
        mem_to_reg  = 1'b0;
        halted      = 1'b0;

        case (state_q)
            S_FETCH: begin
                mem.mem_req = 1'b1;
                if (mem.mem_ready) begin
                    ir_we   = 1'b1;
                    pc_we   = 1'b1;
                    state_d = S_DECODE;
                end else begin
                    mem_wait = 1'b1;
                end
            end
            S_DECODE: begin
                case (dec_kind)
                    K_SYSCALL: begin state_d = S_HALT; cause_d = CAUSE_SYSCALL; end
                    K_ILLEGAL: begin state_d = S_HALT; cause_d = CAUSE_ILLEGAL; end
                    default:   state_d = S_EXEC;
                endcase
            end
            S_EXEC: begin
                alu4      = dec_alu;
                alu_src   = dec_imm;
                shift     = dec_shift;
                shift_var = dec_shvar;
                usign     = dec_usign;
                case (dec_kind)
                    K_ALU:       state_d = S_WB;
                    K_LW, K_SW:  state_d = S_MEM;
                    K_BEQ: begin pc_we = alu_zero;  pc_src = 2'd1; state_d = S_FETCH; end
                    K_BNE: begin pc_we = ~alu_zero; pc_src = 2'd1; state_d = S_FETCH; end
                    K_J:   begin pc_we = 1'b1;      pc_src = 2'd2; state_d = S_FETCH; end
                    K_JAL: begin
                        pc_we   = 1'b1;
                        pc_src  = 2'd2;
                        reg_we  = 1'b1;
                        jal     = 1'b1;
                        state_d = S_FETCH;
                    end
                    K_JR:  begin pc_we = 1'b1;      pc_src = 2'd3; state_d = S_FETCH; end
                    default:     state_d = S_FETCH;
                endcase
            end
            S_MEM: begin
                mem.mem_req = 1'b1;
                mem.i_or_d  = 1'b1;
                mem.mem_we  = (dec_kind == K_SW);
                if (mem.mem_ready) begin
                    state_d = (dec_kind == K_SW) ? S_FETCH : S_WB;
                end else begin
                    mem_wait = 1'b1;
                end
            end
            S_WB: begin
                reg_we     = 1'b1;
                reg_dst    = (op == OP_RTYPE);
                mem_to_reg = (dec_kind == K_LW);
                load_imm   = (op == OP_LUI);
                state_d    = S_FETCH;
            end
            S_HALT: halted = 1'b1;
            default: state_d = S_FETCH;
        endcase

        // A completing mem_ready clears mem_wait, so it beats the limit.
        if ((MEM_TIMEOUT != 0) && mem_wait && (tmo_q == TMO_W'(TMO_LIMIT))) begin
            state_d = S_HALT;
            cause_d = CAUSE_TIMEOUT;
        end

        // The only transitions back to FETCH are instruction completions.
        if ((state_d == S_FETCH) && (state_q inside {S_EXEC, S_MEM, S_WB})) begin
            retired_d = retired_q + CNT_W'(1);
        end

        // Any state change starts a fresh wait window.
        if (state_d != state_q) begin
            tmo_d = '0;
        end else if (mem_wait) begin
            tmo_d = tmo_q + TMO_W'(1);
        end

        // The state register still holds its pre-reset value during the
        // reset cycle, so the strobes are forced quiet combinationally.
        if (rst) begin
            mem.mem_req = 1'b0;
            mem.mem_we  = 1'b0;
            mem.i_or_d  = 1'b0;
            ir_we       = 1'b0;
            pc_we       = 1'b0;
            pc_src      = 2'd0;
            alu4        = 4'b0000;
            alu_src     = 1'b0;
            shift       = 1'b0;
            shift_var   = 1'b0;
            usign       = 1'b0;
            load_imm    = 1'b0;
            reg_we      = 1'b0;
            reg_dst     = 1'b0;
            jal         = 1'b0;
            mem_to_reg  = 1'b0;
            halted      = 1'b0;
        end
    end

    // NOTE: registers use non-blocking assignments so every flop samples the
    // pre-edge value of its _d input regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            cause_q   <= CAUSE_NONE;
            retired_q <= '0;
            tmo_q     <= '0;
        end else begin
            state_q   <= state_d;
            cause_q   <= cause_d;
            retired_q <= retired_d;
            tmo_q     <= tmo_d;
        end
    end

    assign aluop      = ALUOP_W'(alu4);
    assign halt_cause = cause_q;
    assign retired    = retired_q;

endmodule

// File: tb/tb_mc_controller.sv
// -----------------------------------------------------------------------------
// tb_mc_controller
// Bench for mc_controller. A table of supported instructions (op/funct plus
// the EXEC-stage controls each must produce) drives an instruction-level
// model: for every instruction the bench expands the phase sequence
// (fetch waits, decode, execute, memory waits, writeback) into expected
// strobes cycle by cycle. A small retired counter (modulo 2^CNT_W, with a
// narrow CNT_W to exercise wrap) is kept alongside. Directed sequences cover
// timeouts, halts and reset in the middle of a memory access.
// -----------------------------------------------------------------------------
module tb_mc_controller;

    localparam int ALUOP_W     = 4;
    localparam int MEM_TIMEOUT = 16;
    localparam int CNT_W       = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic [5:0]         op, funct;
    logic               alu_zero;
    logic               ir_we, pc_we, alu_src, shift, shift_var, usign;
    logic               load_imm, reg_we, reg_dst, jal, mem_to_reg, halted;
    logic [1:0]         pc_src, halt_cause;
    logic [ALUOP_W-1:0] aluop;
    logic [CNT_W-1:0]   retired;

    mc_controller_if mem_if ();

    mc_controller #(
        .ALUOP_W    (ALUOP_W),
        .MEM_TIMEOUT(MEM_TIMEOUT),
        .CNT_W      (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .mem       (mem_if.master),
        .op        (op),
        .funct     (funct),
        .alu_zero  (alu_zero),
        .ir_we     (ir_we),
        .pc_we     (pc_we),
        .pc_src    (pc_src),
        .aluop     (aluop),
        .alu_src   (alu_src),
        .shift     (shift),
        .shift_var (shift_var),
        .usign     (usign),
        .load_imm  (load_imm),
        .reg_we    (reg_we),
        .reg_dst   (reg_dst),
        .jal       (jal),
        .mem_to_reg(mem_to_reg),
        .halted    (halted),
        .halt_cause(halt_cause),
        .retired   (retired)
    );

    always #5 clk = ~clk;

    typedef enum {K_ALU, K_LW, K_SW, K_BEQ, K_BNE, K_J, K_JAL, K_JR} kind_e;

    typedef struct {
        string      name;
        logic [5:0] op;
        logic [5:0] funct;
        kind_e      kind;
        logic [3:0] aluop;
        logic       alu_src;
        logic       shift;
        logic       shift_var;
        logic       usign;
    } vec_t;

    typedef struct packed {
        logic               mem_req;
        logic               mem_we;
        logic               i_or_d;
        logic               ir_we;
        logic               pc_we;
        logic [1:0]         pc_src;
        logic [ALUOP_W-1:0] aluop;
        logic               alu_src;
        logic               shift;
        logic               shift_var;
        logic               usign;
        logic               load_imm;
        logic               reg_we;
        logic               reg_dst;
        logic               jal;
        logic               mem_to_reg;
        logic               halted;
    } obs_t;

    vec_t tbl[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   model_ret = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic obs_t observe();
        obs_t o;
        o.mem_req    = mem_if.mem_req;
        o.mem_we     = mem_if.mem_we;
        o.i_or_d     = mem_if.i_or_d;
        o.ir_we      = ir_we;
        o.pc_we      = pc_we;
        o.pc_src     = pc_src;
        o.aluop      = aluop;
        o.alu_src    = alu_src;
        o.shift      = shift;
        o.shift_var  = shift_var;
        o.usign      = usign;
        o.load_imm   = load_imm;
        o.reg_we     = reg_we;
        o.reg_dst    = reg_dst;
        o.jal        = jal;
        o.mem_to_reg = mem_to_reg;
        o.halted     = halted;
        return o;
    endfunction

    task automatic add_vec(input string n, input logic [5:0] o, input logic [5:0] f,
                           input kind_e k, input logic [3:0] a, input logic s,
                           input logic sh, input logic sv, input logic u);
        vec_t v;
        v.name = n; v.op = o; v.funct = f; v.kind = k; v.aluop = a;
        v.alu_src = s; v.shift = sh; v.shift_var = sv; v.usign = u;
        tbl.push_back(v);
    endtask

    // One clock cycle: inputs are already applied, outputs are compared at
    // the falling edge, then time advances to just after the next rising edge.
    task automatic cyc(input string name, input obs_t exp);
        @(negedge clk);
        check(name, 32'(observe()), 32'(exp));
        @(posedge clk);
        #1;
    endtask

    // Registered outputs are stable just after the rising edge.
    task automatic check_regs(input string name, input int exp_ret, input int exp_cause);
        check({name, "_retired"}, 32'(retired), 32'(exp_ret));
        check({name, "_cause"}, 32'(halt_cause), 32'(exp_cause));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        mem_if.mem_ready = 1'($urandom);
        op = 6'($urandom); funct = 6'($urandom); alu_zero = 1'($urandom);
        cyc("reset_quiet", '0);
        rst = 1'b0;
        mem_if.mem_ready = 1'b0;
        model_ret = 0;
        check_regs("after_reset", 0, 0);
    endtask

    task automatic fetch_phase(input string name, input int wf);
        obs_t e;
        for (int k = 0; k <= wf; k++) begin
            mem_if.mem_ready = (k == wf);
            op = 6'($urandom); funct = 6'($urandom); alu_zero = 1'($urandom);
            e = '0;
            e.mem_req = 1'b1;
            if (k == wf) begin
                e.ir_we = 1'b1;
                e.pc_we = 1'b1;
            end
            cyc({name, "_fetch"}, e);
        end
    endtask

    task automatic run_instr(input vec_t v, input int wf, input int wm, input logic zero);
        obs_t e;
        bit   r_type = (v.op == 6'h00);
        check_regs({v.name, "_start"}, model_ret, 0);
        fetch_phase(v.name, wf);

        op = v.op;
        funct = r_type ? v.funct : 6'($urandom);
        mem_if.mem_ready = 1'($urandom);
        cyc({v.name, "_decode"}, '0);

        alu_zero = zero;
        e = '0;
        e.aluop = v.aluop; e.alu_src = v.alu_src; e.shift = v.shift;
        e.shift_var = v.shift_var; e.usign = v.usign;
        case (v.kind)
            K_BEQ: begin e.pc_we = zero;  e.pc_src = 2'd1; end
            K_BNE: begin e.pc_we = ~zero; e.pc_src = 2'd1; end
            K_J:   begin e.pc_we = 1'b1;  e.pc_src = 2'd2; end
            K_JAL: begin e.pc_we = 1'b1;  e.pc_src = 2'd2; e.reg_we = 1'b1; e.jal = 1'b1; end
            K_JR:  begin e.pc_we = 1'b1;  e.pc_src = 2'd3; end
            default: ;
        endcase
        cyc({v.name, "_exec"}, e);

        if (v.kind == K_LW || v.kind == K_SW) begin
            for (int k = 0; k <= wm; k++) begin
                mem_if.mem_ready = (k == wm);
                alu_zero = 1'($urandom);
                e = '0;
                e.mem_req = 1'b1; e.i_or_d = 1'b1; e.mem_we = (v.kind == K_SW);
                cyc({v.name, "_mem"}, e);
            end
        end

        if (v.kind == K_ALU || v.kind == K_LW) begin
            mem_if.mem_ready = 1'($urandom);
            e = '0;
            e.reg_we = 1'b1;
            e.reg_dst = r_type;
            e.mem_to_reg = (v.kind == K_LW);
            e.load_imm = (v.op == 6'h0f);
            cyc({v.name, "_wb"}, e);
        end
        mem_if.mem_ready = 1'b0;
        model_ret = (model_ret + 1) % (1 << CNT_W);
    endtask

    task automatic expect_halt(input string name, input int cause, input int cycles);
        obs_t e;
        e = '0;
        e.halted = 1'b1;
        for (int k = 0; k < cycles; k++) begin
            mem_if.mem_ready = 1'($urandom);
            op = 6'($urandom); funct = 6'($urandom); alu_zero = 1'($urandom);
            cyc({name, "_halted"}, e);
        end
        check_regs(name, model_ret, cause);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        obs_t e;
        vec_t v;
        int   lw_idx = 0, sw_idx = 0;

        add_vec("add",   6'h00, 6'h20, K_ALU, 4'b0101, 0, 0, 0, 0);
        add_vec("addu",  6'h00, 6'h21, K_ALU, 4'b0101, 0, 0, 0, 1);
        add_vec("sub",   6'h00, 6'h22, K_ALU, 4'b0110, 0, 0, 0, 0);
        add_vec("and",   6'h00, 6'h24, K_ALU, 4'b0111, 0, 0, 0, 0);
        add_vec("or",    6'h00, 6'h25, K_ALU, 4'b1000, 0, 0, 0, 0);
        add_vec("nor",   6'h00, 6'h27, K_ALU, 4'b1010, 0, 0, 0, 0);
        add_vec("slt",   6'h00, 6'h2a, K_ALU, 4'b1011, 0, 0, 0, 0);
        add_vec("sltu",  6'h00, 6'h2b, K_ALU, 4'b1100, 0, 0, 0, 0);
        add_vec("sll",   6'h00, 6'h00, K_ALU, 4'b0000, 0, 1, 0, 0);
        add_vec("srl",   6'h00, 6'h02, K_ALU, 4'b0010, 0, 1, 0, 0);
        add_vec("sra",   6'h00, 6'h03, K_ALU, 4'b0001, 0, 1, 0, 0);
        add_vec("sllv",  6'h00, 6'h04, K_ALU, 4'b0000, 0, 0, 1, 0);
        add_vec("srav",  6'h00, 6'h07, K_ALU, 4'b0001, 0, 0, 1, 0);
        add_vec("jr",    6'h00, 6'h08, K_JR,  4'b0101, 0, 0, 0, 0);
        add_vec("addi",  6'h08, 6'h00, K_ALU, 4'b0101, 1, 0, 0, 0);
        add_vec("addiu", 6'h09, 6'h00, K_ALU, 4'b0101, 1, 0, 0, 1);
        add_vec("andi",  6'h0c, 6'h00, K_ALU, 4'b0111, 1, 0, 0, 0);
        add_vec("ori",   6'h0d, 6'h00, K_ALU, 4'b1000, 1, 0, 0, 0);
        add_vec("slti",  6'h0a, 6'h00, K_ALU, 4'b1011, 1, 0, 0, 0);
        add_vec("lui",   6'h0f, 6'h00, K_ALU, 4'b0101, 1, 0, 0, 0);
        add_vec("lw",    6'h23, 6'h00, K_LW,  4'b0101, 1, 0, 0, 0);
        add_vec("sw",    6'h2b, 6'h00, K_SW,  4'b0101, 1, 0, 0, 0);
        add_vec("beq",   6'h04, 6'h00, K_BEQ, 4'b0110, 0, 0, 0, 0);
        add_vec("bne",   6'h05, 6'h00, K_BNE, 4'b0110, 0, 0, 0, 0);
        add_vec("j",     6'h02, 6'h00, K_J,   4'b0101, 0, 0, 0, 0);
        add_vec("jal",   6'h03, 6'h00, K_JAL, 4'b0101, 0, 0, 0, 0);
        foreach (tbl[i]) begin
            if (tbl[i].kind == K_LW) lw_idx = i;
            if (tbl[i].kind == K_SW) sw_idx = i;
        end

        rst = 1'b1;
        mem_if.mem_ready = 1'b0;
        op = '0; funct = '0; alu_zero = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // Every supported instruction, zero wait states, both alu_zero values.
        foreach (tbl[i]) begin
            run_instr(tbl[i], 0, 0, 1'b0);
            run_instr(tbl[i], 0, 0, 1'b1);
        end

        // lw with three memory wait states; fetch answered on the 16th request.
        run_instr(tbl[lw_idx], 0, 3, 1'b0);
        run_instr(tbl[sw_idx], 15, 15, 1'b0);

        // Random program with random wait states (retired wraps at 2^CNT_W).
        for (int n = 0; n < 80; n++) begin
            v = tbl[$urandom_range(0, tbl.size() - 1)];
            run_instr(v,
                      ($urandom_range(0, 7) == 0) ? 15 : int'($urandom_range(0, 3)),
                      ($urandom_range(0, 7) == 0) ? 15 : int'($urandom_range(0, 3)),
                      1'($urandom));
        end

        // Fetch timeout: 16 unanswered request cycles, then sticky HALT.
        do_reset();
        run_instr(tbl[0], 0, 0, 1'b0);
        for (int k = 0; k < MEM_TIMEOUT; k++) begin
            mem_if.mem_ready = 1'b0;
            e = '0;
            e.mem_req = 1'b1;
            cyc("fetch_tmo_wait", e);
        end
        expect_halt("fetch_tmo", 3, 4);

        // Memory-stage timeout on a store.
        do_reset();
        fetch_phase("sw_tmo", 0);
        op = 6'h2b; funct = 6'($urandom);
        cyc("sw_tmo_decode", '0);
        e = '0; e.aluop = 4'b0101; e.alu_src = 1'b1;
        cyc("sw_tmo_exec", e);
        for (int k = 0; k < MEM_TIMEOUT; k++) begin
            mem_if.mem_ready = 1'b0;
            e = '0; e.mem_req = 1'b1; e.i_or_d = 1'b1; e.mem_we = 1'b1;
            cyc("sw_tmo_mem", e);
        end
        expect_halt("mem_tmo", 3, 3);

        // Syscall after five instructions.
        do_reset();
        for (int n = 0; n < 5; n++) begin
            run_instr(tbl[$urandom_range(0, tbl.size() - 1)], 1, 1, 1'($urandom));
        end
        fetch_phase("syscall", 0);
        op = 6'h00; funct = 6'h0c;
        cyc("syscall_decode", '0);
        expect_halt("syscall", 1, 3);

        // Illegal opcode, then illegal funct.
        do_reset();
        run_instr(tbl[1], 0, 0, 1'b0);
        fetch_phase("ill_op", 0);
        op = 6'h3f; funct = 6'($urandom);
        cyc("ill_op_decode", '0);
        expect_halt("ill_op", 2, 3);

        do_reset();
        fetch_phase("ill_funct", 2);
        op = 6'h00; funct = 6'h01;
        cyc("ill_funct_decode", '0);
        expect_halt("ill_funct", 2, 2);

        // Reset in the middle of a store's memory wait, then normal recovery.
        do_reset();
        run_instr(tbl[2], 0, 0, 1'b0);
        fetch_phase("rst_mid_mem", 0);
        op = 6'h2b; funct = 6'($urandom);
        cyc("rst_mid_mem_decode", '0);
        e = '0; e.aluop = 4'b0101; e.alu_src = 1'b1;
        cyc("rst_mid_mem_exec", e);
        for (int k = 0; k < 2; k++) begin
            mem_if.mem_ready = 1'b0;
            e = '0; e.mem_req = 1'b1; e.i_or_d = 1'b1; e.mem_we = 1'b1;
            cyc("rst_mid_mem_wait", e);
        end
        do_reset();
        run_instr(tbl[lw_idx], 2, 1, 1'b0);
        check_regs("final", model_ret, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
